// File: rtl/servant_timer_pkg.sv
// Shared definitions for the servant machine-timer controller: register map,
// CTRL/STATUS bit positions, sleep/wake state encoding and a byte-lane merge helper.
package servant_timer_pkg;

  localparam logic [1:0] AdrMtime    = 2'd0;
  localparam logic [1:0] AdrMtimecmp = 2'd1;
  localparam logic [1:0] AdrCtrl     = 2'd2;
  localparam logic [1:0] AdrStatus   = 2'd3;

  localparam int unsigned CtrlEnBit     = 0;
  localparam int unsigned CtrlIeBit     = 1;
  localparam int unsigned CtrlPreLsb    = 8;
  localparam int unsigned StatPendBit   = 0;
  localparam int unsigned StatAsleepBit = 1;

  typedef enum logic [1:0] {
    StRun,
    StSleep,
    StWake
  } wake_state_e;

  function automatic logic [31:0] apply_sel(logic [31:0] old_val, logic [31:0] wdat,
                                            logic [3:0] sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = wdat[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/servant_timer_ctrl_if.sv
// Servant-style Wishbone slave bus (combined cyc/stb) for the timer controller.
interface servant_timer_ctrl_if;
  logic [1:0]  wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic [31:0] wb_rdt;
  logic        wb_ack;

  modport master (
    output wb_adr, wb_dat, wb_sel, wb_we, wb_cyc,
    input  wb_rdt, wb_ack
  );

  modport slave (
    input  wb_adr, wb_dat, wb_sel, wb_we, wb_cyc,
    output wb_rdt, wb_ack
  );
endinterface

// File: rtl/servant_timer_wake_fsm.sv
// Sleep/wake sequencer: parks the core on sleep_req and releases it with a
// one-cycle wakeup pulse once any interrupt is seen.
module servant_timer_wake_fsm
  import servant_timer_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sleep_req_i,
  input  logic irq_i,
  output logic asleep_o,
  output logic wakeup_o
);

  wake_state_e state_q, state_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StRun;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    asleep_o = 1'b0;
    wakeup_o = 1'b0;
    unique case (state_q)
      StRun: begin
        if (sleep_req_i) state_d = StSleep;
      end
      StSleep: begin
        asleep_o = 1'b1;
        if (irq_i) state_d = StWake;
      end
      StWake: begin
        wakeup_o = 1'b1;
        state_d  = StRun;
      end
      default: state_d = StRun;
    endcase
  end

endmodule

// File: rtl/servant_timer_ctrl.sv
// Wishbone machine-timer controller: mtime/mtimecmp, sticky PEND, timer_irq and
// sleep/wake sequencing. Prescaler present only when SERVANT_TIMER_PRESCALER_EN is defined.
module servant_timer_ctrl
  import servant_timer_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter string       RESET_STRATEGY = "MINI"
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  servant_timer_ctrl_if.slave  bus,
  input  logic                 sleep_req,
  input  logic                 ext_irq,
  output logic                 timer_irq,
  output logic                 wakeup
);

  localparam bit NoReset = (RESET_STRATEGY == "NONE");

  logic [WIDTH-1:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic             en_q, en_d, ie_q, ie_d, pend_q, pend_d, ack_q, ack_d;
  logic [31:0]      rdt_q, rdt_d, mtime_ext, cmp_ext, mtime_merged, cmp_merged, ctrl_rd;
  logic             req, wr, wr_mtime, wr_cmp, wr_ctrl, wr_stat, tick, asleep;

  // An ack cycle never starts a new request, forcing two cycles per transfer.
  assign req      = bus.wb_cyc & ~ack_q;
  assign wr       = req & bus.wb_we;
  assign wr_mtime = wr && (bus.wb_adr == AdrMtime);
  assign wr_cmp   = wr && (bus.wb_adr == AdrMtimecmp);
  assign wr_ctrl  = wr && (bus.wb_adr == AdrCtrl);
  assign wr_stat  = wr && (bus.wb_adr == AdrStatus);

  assign mtime_ext    = 32'(mtime_q);
  assign cmp_ext      = 32'(mtimecmp_q);
  assign mtime_merged = apply_sel(mtime_ext, bus.wb_dat, bus.wb_sel);
  assign cmp_merged   = apply_sel(cmp_ext, bus.wb_dat, bus.wb_sel);

`ifdef SERVANT_TIMER_PRESCALER_EN
  logic [7:0] pre_cnt_q, pre_cnt_d, presc_q, presc_d;

  always_comb begin
    presc_d   = presc_q;
    pre_cnt_d = 8'd0;
    tick      = 1'b0;
    if (en_q) begin
      if (pre_cnt_q == presc_q) tick = 1'b1;
      else                      pre_cnt_d = pre_cnt_q + 8'd1;
    end
    if (wr_ctrl && bus.wb_sel[1]) begin
      presc_d   = bus.wb_dat[CtrlPreLsb +: 8];
      pre_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      pre_cnt_q <= 8'd0;
      presc_q   <= 8'd0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      presc_q   <= presc_d;
    end
  end

  assign ctrl_rd = {16'd0, presc_q, 6'd0, ie_q, en_q};
`else
  assign tick    = en_q;
  assign ctrl_rd = {30'd0, ie_q, en_q};
`endif

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    ie_d       = ie_q;
    // Bus write to MTIME overrides the tick increment.
    if (wr_mtime)  mtime_d = mtime_merged[WIDTH-1:0];
    else if (tick) mtime_d = mtime_q + WIDTH'(1);
    if (wr_cmp) mtimecmp_d = cmp_merged[WIDTH-1:0];
    if (wr_ctrl && bus.wb_sel[0]) begin
      en_d = bus.wb_dat[CtrlEnBit];
      ie_d = bus.wb_dat[CtrlIeBit];
    end
    // A match in the same cycle wins over write-1-to-clear.
    pend_d = (en_q && (mtime_q == mtimecmp_q)) ||
             (pend_q && !(wr_stat && bus.wb_sel[0] && bus.wb_dat[StatPendBit]));
  end

  always_comb begin
    ack_d = req;
    rdt_d = 32'd0;
    if (req) begin
      unique case (bus.wb_adr)
        AdrMtime:    rdt_d = mtime_ext;
        AdrMtimecmp: rdt_d = cmp_ext;
        AdrCtrl:     rdt_d = ctrl_rd;
        AdrStatus:   rdt_d = {30'd0, asleep, pend_q};
        default:     rdt_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      en_q   <= 1'b0;
      ie_q   <= 1'b0;
      pend_q <= 1'b0;
      ack_q  <= 1'b0;
      rdt_q  <= 32'd0;
    end else begin
      en_q   <= en_d;
      ie_q   <= ie_d;
      pend_q <= pend_d;
      ack_q  <= ack_d;
      rdt_q  <= rdt_d;
    end
  end

  if (NoReset) begin : g_cnt_noreset
    always_ff @(posedge wb_clk) begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end else begin : g_cnt_reset
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
        mtime_q    <= '0;
        mtimecmp_q <= '1;
      end else begin
        mtime_q    <= mtime_d;
        mtimecmp_q <= mtimecmp_d;
      end
    end
  end

  assign bus.wb_ack = ack_q;
  assign bus.wb_rdt = rdt_q;
  assign timer_irq  = pend_q & ie_q;

  servant_timer_wake_fsm u_wake_fsm (
    .clk_i       (wb_clk),
    .rst_ni      (wb_rst_n),
    .sleep_req_i (sleep_req),
    .irq_i       (timer_irq | ext_irq),
    .asleep_o    (asleep),
    .wakeup_o    (wakeup)
  );

endmodule
